fpu_arbiter: RTL

//   Shares one fpu instance among NREQ requesters (CPU microcode, DMA-side math helper, ...).

---
 rtl/pa_fpu.sv | 12 +
 rtl/fpu_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pa_fpu.sv
// Shared fpu definitions: the operation encoding understood by the fpu core.
package pa_fpu;

  typedef enum logic [2:0] {
    op_add  = 3'd0,
    op_sub  = 3'd1,
    op_mul  = 3'd2,
    op_div  = 3'd3,
    op_sqrt = 3'd4
  } e_fpu_op;

endpackage

// File: rtl/fpu_arbiter.sv
// fpu_arbiter: shares one fpu among NREQ requesters with round-robin arbitration.
// The winner's operands and op are latched and driven on the fpu start/cmd_end handshake.
// The fpu result is returned to the winner with a one-cycle done pulse. A watchdog aborts
// a command that never completes, returning a quiet NaN with an error pulse.
//
// Ports:
//   clk          system clock, rising edge
//   arst         asynchronous reset, active-low
//   req          per-requester request level, held until done[i]
//   req_a/req_b  per-requester operands, slice i = [32*i +: 32]
//   req_op       per-requester fpu operation
//   done         one-cycle pulse to the served requester
//   error        one-cycle pulse alongside done when the command timed out
//   result       result of the last completed command, valid while done != 0
//   fpu_start    to fpu .start
//   fpu_a/fpu_b  to fpu .a_operand / .b_operand
//   fpu_op       to fpu .operation
//   fpu_cmd_end  from fpu .cmd_end
//   fpu_busy     from fpu .busy
//   fpu_result   from fpu .ieee_packet_out
//   owner        index of the current/last granted requester
module fpu_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       arst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*32-1:0]         req_a,
  input  logic [NREQ*32-1:0]         req_b,
  input  pa_fpu::e_fpu_op            req_op [NREQ],
  output logic [NREQ-1:0]            done,
  output logic [NREQ-1:0]            error,
  output logic [31:0]                result,
  output logic                       fpu_start,
  output logic [31:0]                fpu_a,
  output logic [31:0]                fpu_b,
  output pa_fpu::e_fpu_op            fpu_op,
  input  logic                       fpu_cmd_end,
  input  logic                       fpu_busy,
  input  logic [31:0]                fpu_result,
  output logic [$clog2(NREQ)-1:0]    owner
);

  localparam int unsigned IdxW = $clog2(NREQ);
  localparam int unsigned WdW  = $clog2(TIMEOUT);
  localparam logic [31:0] QNaN = 32'h7FC0_0000;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     rr_q, rr_d;
  logic [IdxW-1:0]     owner_q, owner_d;
  logic [WdW-1:0]      wd_q, wd_d;
  logic [31:0]         fpu_a_q, fpu_a_d;
  logic [31:0]         fpu_b_q, fpu_b_d;
  pa_fpu::e_fpu_op     fpu_op_q, fpu_op_d;
  logic                fpu_start_q, fpu_start_d;
  logic [31:0]         result_q, result_d;
  logic [NREQ-1:0]     done_q, done_d;
  logic [NREQ-1:0]     error_q, error_d;

  logic [31:0]         a_arr [NREQ];
  logic [31:0]         b_arr [NREQ];
  logic                gnt_valid;
  logic [IdxW-1:0]     gnt_idx;
  logic [IdxW:0]       cand;
  logic [NREQ-1:0]     owner_oh;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign a_arr[g] = req_a[32*g +: 32];
    assign b_arr[g] = req_b[32*g +: 32];
  end

  // First requester at or after the rr pointer, wrapping past NREQ-1.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_q} + (IdxW+1)'(k);
      if (cand >= (IdxW+1)'(NREQ)) begin
        cand = cand - (IdxW+1)'(NREQ);
      end
      if (!gnt_valid && req[cand[IdxW-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand[IdxW-1:0];
      end
    end
  end

  assign owner_oh = {{(NREQ-1){1'b0}}, 1'b1} << owner_q;

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    owner_d     = owner_q;
    wd_d        = wd_q;
    fpu_a_d     = fpu_a_q;
    fpu_b_d     = fpu_b_q;
    fpu_op_d    = fpu_op_q;
    fpu_start_d = fpu_start_q;
    result_d    = result_q;
    done_d      = '0;
    error_d     = '0;

    unique case (state_q)
      StIdle: begin
        if (gnt_valid && !fpu_busy) begin
          // Latch the winner's command so requester changes cannot disturb it.
          owner_d     = gnt_idx;
          fpu_a_d     = a_arr[gnt_idx];
          fpu_b_d     = b_arr[gnt_idx];
          fpu_op_d    = req_op[gnt_idx];
          fpu_start_d = 1'b1;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        wd_d    = '0;
        state_d = StWait;
      end
      StWait: begin
        if (fpu_cmd_end) begin
          result_d    = fpu_result;
          fpu_start_d = 1'b0;
          done_d      = owner_oh;
          state_d     = StDone;
        end else if (wd_q == WdW'(TIMEOUT - 1)) begin
          result_d    = QNaN;
          fpu_start_d = 1'b0;
          done_d      = owner_oh;
          error_d     = owner_oh;
          state_d     = StDone;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      StDone: begin
        if (owner_q == IdxW'(NREQ - 1)) begin
          rr_d = '0;
        end else begin
          rr_d = owner_q + 1'b1;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q     <= StIdle;
      rr_q        <= '0;
      owner_q     <= '0;
      wd_q        <= '0;
      fpu_a_q     <= '0;
      fpu_b_q     <= '0;
      fpu_op_q    <= pa_fpu::op_add;
      fpu_start_q <= 1'b0;
      result_q    <= '0;
      done_q      <= '0;
      error_q     <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      owner_q     <= owner_d;
      wd_q        <= wd_d;
      fpu_a_q     <= fpu_a_d;
      fpu_b_q     <= fpu_b_d;
      fpu_op_q    <= fpu_op_d;
      fpu_start_q <= fpu_start_d;
      result_q    <= result_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign done      = done_q;
  assign error     = error_q;
  assign result    = result_q;
  assign fpu_start = fpu_start_q;
  assign fpu_a     = fpu_a_q;
  assign fpu_b     = fpu_b_q;
  assign fpu_op    = fpu_op_q;
  assign owner     = owner_q;

endmodule
